// File: rtl/fxp2fp25_enc_if.sv
// Stream interface for fxp2fp25_enc: fixed-point input handshake and
// encoded floating-point output handshake.
interface fxp2fp25_enc_if;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [4:0]  out_man;
  logic        out_denorm;
  logic        out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_man, out_denorm, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_man, out_denorm, out_sat
  );
endinterface

// File: rtl/fxp2fp25_enc.sv
// Two-stage elastic encoder: 20-bit signed fixed-point to a small float
// (sign, 3-bit exponent, 5-bit mantissa). Define FXP2FP25_ENC_RNE_EN for RNE rounding.
module fxp2fp25_enc #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fxp2fp25_enc_if.slave    bus,
  input  logic             sat_cnt_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int unsigned DW = 20;
  localparam int unsigned PW = 5;
  localparam int unsigned EW = 3;
  localparam int unsigned MW = 5;
  localparam int unsigned XW = 4;
  localparam int unsigned SW = 7;

  logic          s1_valid;
  logic          s1_sign;
  logic [DW-1:0] s1_mag;
  logic [PW-1:0] s1_lead;

  logic          s1_en;
  logic          s2_en;

  logic [DW-1:0] in_mag_c;
  logic [PW-1:0] in_lead_c;

  logic [XW-1:0] e_c;
  logic [SW-1:0] s_c;
  logic [EW-1:0] enc_exp_c;
  logic [MW-1:0] enc_man_c;
  logic          enc_denorm_c;
  logic          enc_sat_c;
`ifdef FXP2FP25_ENC_RNE_EN
  logic [DW-1:0] mask_c;
  logic [DW-1:0] rem_c;
  logic [DW-1:0] half_c;
  logic          rnd_up_c;
`endif

  // Elastic handshake: a stage may load whenever the stage after it is free or draining.
  assign s2_en        = ~bus.out_valid | bus.out_ready;
  assign s1_en        = ~s1_valid | s2_en;
  assign bus.in_ready = s1_en;

  // Stage 1 combinational: magnitude and leading-one position.
  always_comb begin
    in_mag_c  = bus.in_data[DW-1] ? DW'(~bus.in_data + DW'(1)) : bus.in_data;
    in_lead_c = '0;
    for (int i = 0; i < int'(DW); i++) begin
      if (in_mag_c[i]) in_lead_c = PW'(i);
    end
  end

  // Stage 2 combinational: normalise, round, pack or clamp.
  always_comb begin
    e_c          = '0;
    s_c          = '0;
    enc_exp_c    = '0;
    enc_man_c    = '0;
    enc_denorm_c = 1'b0;
    enc_sat_c    = 1'b0;
`ifdef FXP2FP25_ENC_RNE_EN
    mask_c       = '0;
    rem_c        = '0;
    half_c       = '0;
    rnd_up_c     = 1'b0;
`endif
    if (s1_mag < DW'(32)) begin
      enc_denorm_c = 1'b1;
      enc_man_c    = s1_mag[MW-1:0];
    end else begin
      e_c = XW'(s1_lead - PW'(5));
      s_c = SW'(s1_mag >> e_c);
`ifdef FXP2FP25_ENC_RNE_EN
      mask_c   = (DW'(1) << e_c) - DW'(1);
      rem_c    = s1_mag & mask_c;
      half_c   = DW'(1) << (e_c - XW'(1));
      rnd_up_c = (e_c != '0) && ((rem_c > half_c) || ((rem_c == half_c) && s_c[0]));
      s_c      = s_c + SW'(rnd_up_c);
      if (s_c[SW-1]) begin
        s_c = SW'(32);
        e_c = e_c + XW'(1);
      end
`endif
      if (e_c > XW'(7)) begin
        enc_exp_c = EW'(7);
        enc_man_c = MW'(31);
        enc_sat_c = 1'b1;
      end else begin
        enc_exp_c = e_c[EW-1:0];
        enc_man_c = MW'(s_c - SW'(32));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_sign        <= 1'b0;
      s1_mag         <= '0;
      s1_lead        <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_sign   <= 1'b0;
      bus.out_exp    <= '0;
      bus.out_man    <= '0;
      bus.out_denorm <= 1'b0;
      bus.out_sat    <= 1'b0;
      sat_cnt        <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign <= bus.in_data[DW-1];
          s1_mag  <= in_mag_c;
          s1_lead <= in_lead_c;
        end
      end
      if (s2_en) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_sign   <= s1_sign;
          bus.out_exp    <= enc_exp_c;
          bus.out_man    <= enc_man_c;
          bus.out_denorm <= enc_denorm_c;
          bus.out_sat    <= enc_sat_c;
        end
      end
      // Clear wins over a same-cycle saturated transfer; count sticks at all-ones.
      if (sat_cnt_clr) begin
        sat_cnt <= '0;
      end else if (bus.out_valid && bus.out_ready && bus.out_sat && (sat_cnt != '1)) begin
        sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end

endmodule
